// File: rtl/idct_coef_src.sv
// Coefficient-stream source: emits 4x4/8x8/16x16 blocks of test-pattern samples
// over a valid/ready handshake, sequencing a programmable number of blocks.
module idct_coef_src #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned GAP    = 0,
  parameter logic [15:0] SEED   = 16'hACE1,
  parameter logic [15:0] DC_VAL = 16'd1024,
  parameter logic [15:0] AMP    = 16'd100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [1:0]        pattern,
  input  logic [7:0]        num_blocks,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic [1:0]        out_mode,
  output logic              busy,
  output logic              done,
  output logic [7:0]        blk_cnt
);

  localparam int unsigned GCW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_GAP, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [7:0]        idx_q, idx_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [1:0]        pat_q, pat_d;
  logic [7:0]        nblk_q, nblk_d;
  logic [GCW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [DATA_W-1:0] out_data_d;
  logic              out_valid_d, out_last_d, busy_d, done_d;
  logic [1:0]        out_mode_d;
  logic [7:0]        blk_cnt_d;

  logic [7:0]  len_m1;
  logic [7:0]  idx_inc;
  logic [15:0] lfsr_nxt;
  logic [15:0] lfsr_adv;
  logic        accept;
  logic        blk_final;
  logic        gap_end;

  // Sample value for a given pattern, block index and current LFSR state
  function automatic logic [DATA_W-1:0] pat_val(input logic [1:0] pat,
                                                input logic [7:0] i,
                                                input logic [15:0] l);
    logic [DATA_W-1:0] v;
    v = '0;
    case (pat)
      2'b00:   v = DATA_W'(i);
      2'b01:   v = (i == 8'd0) ? DATA_W'(DC_VAL) : '0;
      2'b10:   v = DATA_W'(l);
      default: v = i[0] ? (DATA_W'(0) - DATA_W'(AMP)) : DATA_W'(AMP);
    endcase
    return v;
  endfunction

  // Shared handshake/sequencing terms; LFSR only steps while its pattern streams
  always_comb begin
    case (out_mode)
      2'b00:   len_m1 = 8'd15;
      2'b10:   len_m1 = 8'd255;
      default: len_m1 = 8'd63;
    endcase
    idx_inc   = 8'(idx_q + 8'd1);
    lfsr_nxt  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    lfsr_adv  = (pat_q == 2'b10) ? lfsr_nxt : lfsr_q;
    accept    = out_valid && out_ready;
    blk_final = (8'(blk_cnt + 8'd1) == nblk_q);
    gap_end   = (32'(gap_cnt_q) == GAP - 32'd1);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort overrides everything
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (start) state_d = (num_blocks == 8'd0) ? S_DONE : S_STREAM;
        S_STREAM: if (accept && out_last) begin
                    if (blk_final)          state_d = S_DONE;
                    else if (GAP != 32'd0)  state_d = S_GAP;
                    else                    state_d = S_STREAM;
                  end
        S_GAP:    if (gap_end) state_d = S_STREAM;
        S_DONE:   state_d = S_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    idx_d       = idx_q;
    lfsr_d      = lfsr_q;
    pat_d       = pat_q;
    nblk_d      = nblk_q;
    gap_cnt_d   = gap_cnt_q;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    out_last_d  = out_last;
    out_mode_d  = out_mode;
    busy_d      = busy;
    done_d      = 1'b0;
    blk_cnt_d   = blk_cnt;
    if (abort) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          out_mode_d  = (mode == 2'b11) ? 2'b01 : mode;
          pat_d       = pattern;
          nblk_d      = num_blocks;
          blk_cnt_d   = 8'd0;
          busy_d      = 1'b1;
          idx_d       = 8'd0;
          out_valid_d = (num_blocks != 8'd0);
          out_last_d  = 1'b0;
          out_data_d  = pat_val(pattern, 8'd0, lfsr_q);
        end
        S_STREAM: if (accept) begin
          lfsr_d = lfsr_adv;
          if (out_last) begin
            blk_cnt_d  = 8'(blk_cnt + 8'd1);
            idx_d      = 8'd0;
            gap_cnt_d  = '0;
            out_last_d = 1'b0;
            out_data_d = pat_val(pat_q, 8'd0, lfsr_adv);
            if (blk_final || GAP != 32'd0) out_valid_d = 1'b0;
          end else begin
            idx_d      = idx_inc;
            out_data_d = pat_val(pat_q, idx_inc, lfsr_adv);
            out_last_d = (idx_inc == len_m1);
          end
        end
        S_GAP: begin
          gap_cnt_d = GCW'(gap_cnt_q + 1'b1);
          if (gap_end) begin
            out_valid_d = 1'b1;
            out_data_d  = pat_val(pat_q, 8'd0, lfsr_q);
          end
        end
        S_DONE: begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      endcase
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= 8'd0;
      lfsr_q    <= SEED;
      pat_q     <= 2'b00;
      nblk_q    <= 8'd0;
      gap_cnt_q <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_mode  <= 2'b00;
      busy      <= 1'b0;
      done      <= 1'b0;
      blk_cnt   <= 8'd0;
    end else begin
      idx_q     <= idx_d;
      lfsr_q    <= lfsr_d;
      pat_q     <= pat_d;
      nblk_q    <= nblk_d;
      gap_cnt_q <= gap_cnt_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      out_last  <= out_last_d;
      out_mode  <= out_mode_d;
      busy      <= busy_d;
      done      <= done_d;
      blk_cnt   <= blk_cnt_d;
    end
  end

endmodule

// File: tb/tb_idct_coef_src.sv
// Bench for idct_coef_src: behavioural expected-beat list plus a per-cycle monitor.
module tb_idct_coef_src;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned GAP    = 2;
  localparam logic [15:0] SEED   = 16'hACE1;
  localparam logic [15:0] DC_VAL = 16'd1024;
  localparam logic [15:0] AMP    = 16'd100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [1:0]        mode = 2'b00;
  logic [1:0]        pattern = 2'b00;
  logic [7:0]        num_blocks = 8'd0;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic [1:0]        out_mode;
  logic              busy;
  logic              done;
  logic [7:0]        blk_cnt;

  idct_coef_src #(
    .DATA_W(DATA_W), .GAP(GAP), .SEED(SEED), .DC_VAL(DC_VAL), .AMP(AMP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .pattern(pattern), .num_blocks(num_blocks), .out_ready(out_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_mode(out_mode), .busy(busy), .done(done), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        last;
    logic [15:0] lfsr;
  } beat_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rdy_mode = 0;
  beat_t       exp_arr[$];
  logic [15:0] acc_log[$];
  logic [15:0] model_lfsr = SEED;
  logic [1:0]  exp_mode = 2'b00;
  logic        expect_done = 1'b0;

  // monitor-owned
  int          exp_rd = 0;
  int          done_total = 0;
  int          done_cyc = 0;
  int          last_acc_cyc = 0;
  logic        prev_stall = 1'b0, prev_abort = 1'b0, prev_done = 1'b0, prev_last = 1'b0;
  logic [15:0] prev_data = '0;
  logic        in_gap = 1'b0;
  int          gap_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic fb;
    fb = l[15] ^ l[13] ^ l[12] ^ l[10];
    return {l[14:0], fb};
  endfunction

  function automatic logic [15:0] ref_val(input int p, input int i, input logic [15:0] l);
    case (p)
      0:       return 16'(i);
      1:       return (i == 0) ? DC_VAL : 16'd0;
      2:       return l;
      default: return (i % 2 == 0) ? AMP : 16'(16'd0 - AMP);
    endcase
  endfunction

  function automatic logic [15:0] logged(input int i);
    if (i < acc_log.size()) return acc_log[i];
    return 16'hxxxx;
  endfunction

  // Consumer readiness policy: 0 always, 1 toggle, 2 random, 3 hold low
  always @(posedge clk) begin
    #3;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Per-cycle compare against the expected beat list
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      prev_stall = 1'b0; prev_abort = 1'b0; prev_done = 1'b0;
      in_gap = 1'b0; exp_rd = exp_arr.size();
    end else begin
      if (prev_stall && !prev_abort) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
        chk("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid) begin
        chk("valid_expected", 32'(exp_arr.size() > exp_rd), 32'd1);
        chk("busy_with_valid", 32'(busy), 32'd1);
        if (in_gap) begin
          chk("gap_len", 32'(gap_run), 32'(GAP));
          in_gap = 1'b0;
        end
        if (out_ready && exp_arr.size() > exp_rd) begin
          e = exp_arr[exp_rd];
          exp_rd++;
          chk("beat_data", 32'(out_data), 32'(e.data));
          chk("beat_last", 32'(out_last), 32'(e.last));
          chk("beat_mode", 32'(out_mode), 32'(exp_mode));
          acc_log.push_back(out_data);
          last_acc_cyc = cyc;
          if (e.last && exp_arr.size() > exp_rd) begin
            in_gap = 1'b1;
            gap_run = 0;
          end
        end
      end else if (in_gap) begin
        gap_run++;
      end
      if (done) begin
        chk("done_expected", 32'(expect_done), 32'd1);
        chk("done_single", 32'(prev_done), 32'd0);
        chk("done_busy_low", 32'(busy), 32'd0);
        done_total++;
        done_cyc = cyc;
      end
      if (abort) exp_rd = exp_arr.size();
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      prev_abort = abort;
      prev_done  = done;
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic build_exp(input int m, input int p, input int nb);
    beat_t b;
    int len;
    len = (m == 0) ? 16 : (m == 2) ? 256 : 64;
    for (int k = 0; k < nb; k++) begin
      for (int i = 0; i < len; i++) begin
        b.lfsr = model_lfsr;
        b.data = ref_val(p, i, model_lfsr);
        b.last = (i == len - 1);
        exp_arr.push_back(b);
        if (p == 2) model_lfsr = lfsr_step(model_lfsr);
      end
    end
    exp_mode = (m == 3) ? 2'b01 : 2'(m);
  endtask

  // Launch one sequence; abort_at >= 0 cancels when that beat index is presented
  task automatic run_seq(input int m, input int p, input int nb, input int rm,
                         input bit hold_start, input int abort_at, output int base);
    int n, start_cyc, dbase, len;
    len = (m == 0) ? 16 : (m == 2) ? 256 : 64;
    build_exp(m, p, nb);
    base = acc_log.size();
    dbase = done_total;
    expect_done = (abort_at < 0);
    rdy_mode = rm;
    mode = 2'(m); pattern = 2'(p); num_blocks = 8'(nb);
    start = 1'b1;
    start_cyc = cyc;
    tick;
    chk("first_valid_timing", 32'(out_valid), 32'(nb != 0));
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("blk_cnt_cleared", 32'(blk_cnt), 32'd0);
    mode = 2'($urandom); pattern = 2'($urandom); num_blocks = 8'($urandom);
    if (hold_start && nb > 0) begin
      tick;
      tick;
    end
    start = 1'b0;
    if (abort_at >= 0) begin
      n = 0;
      while (!((acc_log.size() - base) == abort_at && out_valid) && n < 5000) begin
        tick;
        n++;
      end
      chk("abort_reached", 32'(n < 5000), 32'd1);
      model_lfsr = exp_arr[exp_rd].lfsr;
      rdy_mode = 3;
      abort = 1'b1;
      tick;
      abort = 1'b0;
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_last", 32'(out_last), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_blk_cnt", 32'(blk_cnt), 32'(abort_at / len));
      repeat (5) tick;
      chk("abort_no_done", 32'(done_total - dbase), 32'd0);
      chk("abort_blk_hold", 32'(blk_cnt), 32'(abort_at / len));
      return;
    end
    n = 0;
    while (done_total == dbase && n < 20000) begin
      tick;
      n++;
    end
    chk("done_seen", 32'(done_total - dbase), 32'd1);
    if (nb == 0) chk("done_latency_empty", 32'(done_cyc - start_cyc), 32'd2);
    else         chk("done_latency", 32'(done_cyc - last_acc_cyc), 32'd2);
    chk("blk_cnt_final", 32'(blk_cnt), 32'(nb));
    chk("beats_left", 32'(exp_arr.size() - exp_rd), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("done_cleared", 32'(done), 32'd0);
    chk("mode_held", 32'(out_mode), 32'(exp_mode));
    expect_done = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base, n, m, p, nb;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_mode", 32'(out_mode), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_blk_cnt", 32'(blk_cnt), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    tick;

    // 8x8 ramp, single block, back-to-back
    run_seq(1, 0, 1, 0, 0, -1, base);
    chk("ramp_first", 32'(logged(base)), 32'd0);
    chk("ramp_last", 32'(logged(base + 63)), 32'd63);

    // 4x4 DC, three blocks with inter-block gaps
    run_seq(0, 1, 3, 0, 0, -1, base);
    chk("dc_first", 32'(logged(base)), 32'd1024);
    chk("dc_second", 32'(logged(base + 1)), 32'd0);
    chk("dc_block2_first", 32'(logged(base + 16)), 32'd1024);

    // 16x16 ramp under a toggling consumer
    run_seq(2, 0, 1, 1, 0, -1, base);
    chk("ramp256_last", 32'(logged(base + 255)), 32'd255);

    // LFSR across two sequences without reset
    run_seq(0, 2, 2, 0, 0, -1, base);
    chk("lfsr_first_is_seed", 32'(logged(base)), 32'hACE1);
    chk("lfsr_second", 32'(logged(base + 1)), 32'h59C3);
    run_seq(0, 2, 1, 2, 1, -1, base);

    // Empty sequence
    run_seq(1, 0, 0, 0, 0, -1, base);

    // Mode 11 reports as 01; alternating sign
    run_seq(3, 3, 2, 2, 0, -1, base);
    chk("alt_even", 32'(logged(base)), 32'd100);
    chk("alt_odd", 32'(logged(base + 1)), 32'hFF9C);

    // Abort at block 2 index 10 of 4, then LFSR continuity afterwards
    run_seq(0, 2, 4, 0, 0, 26, base);
    run_seq(0, 2, 1, 0, 0, -1, base);

    // Abort and start together in IDLE: abort wins
    mode = 2'b01; pattern = 2'b00; num_blocks = 8'd2;
    start = 1'b1; abort = 1'b1;
    tick;
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", 32'(busy), 32'd0);
    chk("abort_start_valid", 32'(out_valid), 32'd0);
    repeat (3) tick;
    chk("abort_start_idle", 32'(busy), 32'd0);

    // Randomised sequences
    for (int r = 0; r < 6; r++) begin
      m  = $urandom_range(0, 3);
      p  = $urandom_range(0, 3);
      nb = $urandom_range(0, 3);
      run_seq(m, p, nb, $urandom_range(0, 2), 1'($urandom_range(0, 1)), -1, base);
    end

    // Reset mid-block
    build_exp(2, 0, 2);
    rdy_mode = 2;
    mode = 2'b10; pattern = 2'b00; num_blocks = 8'd2;
    base = acc_log.size();
    start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    while ((acc_log.size() - base) < 20 && n < 2000) begin
      tick;
      n++;
    end
    chk("reset_reach", 32'(n < 2000), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_data", 32'(out_data), 32'd0);
    chk("mrst_last", 32'(out_last), 32'd0);
    chk("mrst_mode", 32'(out_mode), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_blk_cnt", 32'(blk_cnt), 32'd0);
    model_lfsr = SEED;
    @(posedge clk); #2;
    rst_n = 1'b1;
    tick;

    // Reset restores the LFSR seed
    run_seq(0, 2, 1, 0, 0, -1, base);
    chk("lfsr_after_reset", 32'(logged(base)), 32'hACE1);

    repeat (3) tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
